// File: rtl/uart_baud_ctrl_if.sv
// Config-side handshake between the CPU baud register and uart_baud_ctrl.
// The master drives write strobes; the slave returns ready and completion pulses.
interface uart_baud_ctrl_if;
  logic       cfg_wr_i;
  logic [1:0] cfg_baud_sel_i;
  logic       cfg_ready_o;
  logic       cfg_done_o;
  logic       cfg_err_o;

  modport master (
    output cfg_wr_i,
    output cfg_baud_sel_i,
    input  cfg_ready_o,
    input  cfg_done_o,
    input  cfg_err_o
  );

  modport slave (
    input  cfg_wr_i,
    input  cfg_baud_sel_i,
    output cfg_ready_o,
    output cfg_done_o,
    output cfg_err_o
  );
endinterface

// File: rtl/uart_baud_ctrl.sv
// Sequences run-time baud-rate changes: holds the link, drains tx/rx, switches the
// x16 generator select with a one-cycle counter reset, then waits for the new tick to settle.
module uart_baud_ctrl #(
  parameter logic [1:0]  ResetBaudSel = 2'b11,
  parameter int unsigned SettleTicks  = 16,
  parameter int unsigned TimeoutTicks = 320
) (
  input  logic            clk_i,
  input  logic            rst_i,
  uart_baud_ctrl_if.slave cfg,
  input  logic            tx_busy_i,
  input  logic            rx_busy_i,
  input  logic            baudx16_tick_i,
  output logic [1:0]      baud_sel_o,
  output logic            gen_rst_o,
  output logic            link_hold_o
);

  localparam int unsigned MaxTicks = (TimeoutTicks > SettleTicks) ? TimeoutTicks : SettleTicks;
  localparam int unsigned CntW     = $clog2(MaxTicks + 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TimeoutTicks);
  localparam logic [CntW-1:0] SettleCnt  = CntW'(SettleTicks);

  typedef enum logic [1:0] {StIdle, StDrain, StApply, StSettle} state_e;

  state_e          state_q, state_d;
  logic [1:0]      pend_q, pend_d, pend_nxt;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_step;
  logic [1:0]      sel_q, sel_d;
  logic            gen_rst_q, gen_rst_d;
  logic            hold_q, hold_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    gen_rst_d = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    pend_nxt  = cfg.cfg_wr_i ? cfg.cfg_baud_sel_i : pend_q;
    // Saturating count of ticks seen this cycle; never wraps.
    cnt_step  = (baudx16_tick_i && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

    case (state_q)
      StIdle: begin
        if (cfg.cfg_wr_i) begin
          if (cfg.cfg_baud_sel_i == sel_q) begin
            done_d = 1'b1;
          end else begin
            pend_d  = cfg.cfg_baud_sel_i;
            cnt_d   = '0;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        pend_d = pend_nxt;
        cnt_d  = cnt_step;
        if (!tx_busy_i && !rx_busy_i) begin
          // A write landing on the exit cycle still wins.
          state_d   = StApply;
          sel_d     = pend_nxt;
          gen_rst_d = 1'b1;
        end else if (cnt_step >= TimeoutCnt) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      StApply: begin
        state_d = StSettle;
        cnt_d   = '0;
      end
      StSettle: begin
        cnt_d = cnt_step;
        if (cnt_step >= SettleCnt) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    hold_d  = (state_d != StIdle);
    ready_d = (state_d == StIdle) || (state_d == StDrain);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pend_q    <= '0;
      cnt_q     <= '0;
      sel_q     <= ResetBaudSel;
      gen_rst_q <= 1'b0;
      hold_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      gen_rst_q <= gen_rst_d;
      hold_q    <= hold_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign baud_sel_o      = sel_q;
  assign gen_rst_o       = gen_rst_q;
  assign link_hold_o     = hold_q;
  assign cfg.cfg_ready_o = ready_q;
  assign cfg.cfg_done_o  = done_q;
  assign cfg.cfg_err_o   = err_q;

endmodule
